// File: rtl/twos_comp_to_sign_mag.sv
// rtl/twos_comp_to_sign_mag.sv - bit-serial two's-complement to sign-magnitude decoder
//
// Converts a WIDTH-bit signed value to sign + unsigned magnitude, one bit per
// clock, LSB first. For a negative input the bits are copied up to and including
// the first 1 and the remaining bits are inverted (serial negate). Positive
// inputs pass through unchanged.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   in_data is valid
//   in_ready   block is idle and can accept a value
//   in_data    signed two's-complement input (WIDTH bits)
//   out_valid  result valid, held until out_ready
//   out_ready  downstream accepts the result
//   out_sign   1 = negative
//   out_mag    unsigned magnitude |in_data| (WIDTH bits)
//   out_zero   1 when out_mag == 0

module twos_comp_to_sign_mag #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sign,
    output logic [WIDTH-1:0] out_mag,
    output logic             out_zero
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_sreg;
    logic [WIDTH-1:0] r_mag;
    logic [CW-1:0]    r_cnt;
    logic             r_sign;
    logic             r_seen_one;
    logic             r_out_sign;
    logic             r_zero;

    logic             w_bit;
    logic             w_res_bit;
    logic             w_last;
    logic [WIDTH-1:0] w_mag_next;

    // Serial negate: once a 1 has passed through, every later bit is inverted.
    assign w_bit      = r_sreg[0];
    assign w_res_bit  = (r_sign & r_seen_one) ? ~w_bit : w_bit;
    assign w_mag_next = {w_res_bit, r_mag[WIDTH-1:1]};
    assign w_last     = (r_cnt == LAST_CNT);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: if (in_valid)  w_next_state = S_CONV;
            S_CONV: if (w_last)    w_next_state = S_DONE;
            S_DONE: if (out_ready) w_next_state = S_IDLE;
            default:               w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_sreg     <= '0;
            r_mag      <= '0;
            r_cnt      <= '0;
            r_sign     <= 1'b0;
            r_seen_one <= 1'b0;
            r_out_sign <= 1'b0;
            r_zero     <= 1'b1;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_sreg     <= in_data;
                        r_sign     <= in_data[WIDTH-1];
                        r_cnt      <= '0;
                        r_seen_one <= 1'b0;
                    end
                end
                S_CONV: begin
                    r_sreg     <= r_sreg >> 1;
                    r_mag      <= w_mag_next;
                    r_seen_one <= r_seen_one | w_bit;
                    r_cnt      <= r_cnt + CW'(1);
                    // Sign and zero flag are published together with the final
                    // magnitude bit so all outputs settle on the same edge.
                    if (w_last) begin
                        r_out_sign <= r_sign;
                        r_zero     <= (w_mag_next == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign out_sign  = r_out_sign;
    assign out_mag   = r_mag;
    assign out_zero  = r_zero;

endmodule

// File: tb/tb_twos_comp_to_sign_mag.sv
// tb/tb_twos_comp_to_sign_mag.sv - self-checking bench for twos_comp_to_sign_mag

module tb_twos_comp_to_sign_mag;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic         out_sign;
    logic [W-1:0] out_mag;
    logic         out_zero;

    twos_comp_to_sign_mag #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sign  (out_sign),
        .out_mag   (out_mag),
        .out_zero  (out_zero)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // {zero, sign, mag} from plain signed arithmetic.
    typedef logic [W+1:0] exp_t;

    function automatic exp_t model(input logic [W-1:0] x);
        int           v;
        int           m;
        logic         s;
        logic [W-1:0] mag;
        v   = int'($signed(x));
        s   = (v < 0);
        m   = s ? -v : v;
        mag = W'(m);
        return {(mag == '0), s, mag};
    endfunction

    exp_t q[$];
    bit   b2b = 1'b0;
    bit   have_prev = 1'b0;
    bit   lat_pending = 1'b0;
    int   prev_acc = 0;
    int   acc_cyc = 0;

    // Compare process: tracks accepts and checks every cycle a result is presented.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            lat_pending = 1'b0;
            have_prev   = 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                q.push_back(model(in_data));
                // accept edge, WIDTH conversion edges, handshake edge, one idle cycle
                if (b2b && have_prev)
                    chk("accept_spacing", 32'(cyc - prev_acc), 32'(W + 2));
                prev_acc    = cyc;
                have_prev   = b2b;
                acc_cyc     = cyc;
                lat_pending = 1'b1;
            end
            if (out_valid) begin
                if (lat_pending) begin
                    chk("latency", 32'(cyc - acc_cyc), 32'(W + 1));
                    lat_pending = 1'b0;
                end
                chk("mon_in_ready_busy", 32'(in_ready), 32'd0);
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL mon_unexpected_result: got mag %0h expected no result", out_mag);
                end else begin
                    chk("mon_sign", 32'(out_sign), 32'(q[0][W]));
                    chk("mon_mag",  32'(out_mag),  32'(q[0][W-1:0]));
                    chk("mon_zero", 32'(out_zero), 32'(q[0][W+1]));
                    if (out_ready) void'(q.pop_front());
                end
            end
        end
    end

    task automatic send(input logic [W-1:0] v, input bit keep);
        int n;
        n        = 0;
        in_data  = v;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: got in_ready 0 expected 1");
        end
        @(posedge clk);
        #1;
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic check_result(input string nm, input logic s, input logic [W-1:0] m,
                                input logic z);
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_valid"}, 32'(out_valid), 32'd1);
        chk({nm, "_sign"},  32'(out_sign),  32'(s));
        chk({nm, "_mag"},   32'(out_mag),   32'(m));
        chk({nm, "_zero"},  32'(out_zero),  32'(z));
        @(posedge clk);
        #1;
    endtask

    bit done_rand = 1'b0;

    initial begin
        int n;

        // Reset state
        #23;
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_sign",  32'(out_sign),  32'd0);
        chk("rst_out_mag",   32'(out_mag),   32'd0);
        chk("rst_out_zero",  32'(out_zero),  32'd1);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;

        // Hand-computed directed values
        send(8'h05, 1'b0); check_result("pos5",   1'b0, 8'h05, 1'b0);
        send(8'hFF, 1'b0); check_result("neg1",   1'b1, 8'h01, 1'b0);
        send(8'hEC, 1'b0); check_result("neg20",  1'b1, 8'h14, 1'b0);
        send(8'h80, 1'b0); check_result("minneg", 1'b1, 8'h80, 1'b0);
        send(8'h7F, 1'b0); check_result("maxpos", 1'b0, 8'h7F, 1'b0);
        send(8'h00, 1'b0); check_result("zero",   1'b0, 8'h00, 1'b1);

        // Back-pressure: hold DONE for 20 cycles, a busy in_valid must be ignored
        out_ready = 1'b0;
        send(8'hEC, 1'b0);
        check_result("hold_first", 1'b1, 8'h14, 1'b0);
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            in_valid = (k == 5 || k == 6);
            in_data  = 8'h33;
            @(negedge clk);
            chk("hold_valid",    32'(out_valid), 32'd1);
            chk("hold_mag",      32'(out_mag),   32'h14);
            chk("hold_sign",     32'(out_sign),  32'd1);
            chk("hold_in_ready", 32'(in_ready),  32'd0);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        repeat (3) begin
            @(negedge clk);
            chk("hold_release_valid", 32'(out_valid), 32'd0);
            chk("hold_release_ready", 32'(in_ready),  32'd1);
        end

        // Exhaustive back-to-back sweep with in_valid held high
        @(posedge clk);
        #1;
        b2b = 1'b1;
        for (int i = 0; i < 256; i++) send(8'(i), 1'b1);
        in_valid = 1'b0;
        b2b      = 1'b0;
        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        chk("sweep_drain", 32'(q.size()), 32'd0);
        @(posedge clk);
        #1;

        // Random values, random gaps, random downstream stalls
        fork
            begin
                for (int k = 0; k < 60; k++) begin
                    send(8'($urandom), 1'b0);
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                end
                done_rand = 1'b1;
            end
            begin
                while (!done_rand) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        chk("rand_drain", 32'(q.size()), 32'd0);
        @(posedge clk);
        #1;

        // Reset in the middle of a conversion
        send(8'hD6, 1'b0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready",  32'(in_ready),  32'd1);
        chk("midrst_out_mag",   32'(out_mag),   32'd0);
        chk("midrst_out_zero",  32'(out_zero),  32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("midrst_no_output", 32'(out_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        send(8'h9C, 1'b0);
        check_result("after_rst", 1'b1, 8'h64, 1'b0);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
